// File: rtl/apb_spi_pkg.sv
// rtl/apb_spi_pkg.sv - shared SPI wrapper register map, flash command and sequencer types
package apb_spi_pkg;

    // SPI wrapper register offsets
    localparam logic [7:0] SPI_REG_CTRL = 8'h00;
    localparam logic [7:0] SPI_REG_STAT = 8'h08;
    localparam logic [7:0] SPI_REG_DATA = 8'h10;
    localparam logic [7:0] SPI_REG_SS   = 8'h20;

    // CTRL / STAT bit positions
    localparam int SPI_CTRL_EN_BIT   = 6;
    localparam int SPI_CTRL_MSTR_BIT = 4;
    localparam int SPI_STAT_RFE_BIT  = 0;

    // core enable + master, mode 0
    localparam logic [7:0] SPI_CTRL_INIT = 8'h50;

    // standard NOR read: command followed by 24-bit address
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         HDR_BYTES      = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_CS_ON,
        ST_SEND,
        ST_POLL,
        ST_FETCH,
        ST_PUSH,
        ST_CS_OFF,
        ST_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_ACCESS
    } bus_state_t;

    // Header byte idx of the read command: opcode, then address MSB first
    function automatic logic [7:0] header_byte(input logic [1:0] idx, input logic [23:0] addr);
        case (idx)
            2'd0:    return FLASH_CMD_READ;
            2'd1:    return addr[23:16];
            2'd2:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - single-transfer APB master: idle, setup, access until PREADY
module apb_master_if
    import apb_spi_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              xfer_done,
    output logic [7:0]        xfer_rdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY
);

    bus_state_t bus_state;

    // The idle state is the mandatory PSEL=0 cycle; a request held there launches setup
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            bus_state <= BUS_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            case (bus_state)
                BUS_IDLE: begin
                    if (req) begin
                        PSEL      <= 1'b1;
                        PADDR     <= req_addr;
                        PWRITE    <= req_write;
                        PWDATA    <= req_wdata;
                        bus_state <= BUS_SETUP;
                    end
                end
                BUS_SETUP: begin
                    PENABLE   <= 1'b1;
                    bus_state <= BUS_ACCESS;
                end
                BUS_ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        bus_state <= BUS_IDLE;
                    end
                end
                default: bus_state <= BUS_IDLE;
            endcase
        end
    end

    // Completion is flagged in the accepting access cycle so the sequencer can queue the next request
    assign xfer_done  = (bus_state == BUS_ACCESS) && PREADY;
    assign xfer_rdata = PRDATA;

endmodule

// File: rtl/apb_spi_flash_reader.sv
// rtl/apb_spi_flash_reader.sv - APB sequencer fetching an SPI NOR block into a byte stream
module apb_spi_flash_reader
    import apb_spi_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                LEN_W     = 16,
    parameter logic [ADDR_W-1:0] REG_CTRL  = ADDR_W'(SPI_REG_CTRL),
    parameter logic [ADDR_W-1:0] REG_STAT  = ADDR_W'(SPI_REG_STAT),
    parameter logic [ADDR_W-1:0] REG_DATA  = ADDR_W'(SPI_REG_DATA),
    parameter logic [ADDR_W-1:0] REG_SS    = ADDR_W'(SPI_REG_SS),
    parameter logic [7:0]        CTRL_INIT = SPI_CTRL_INIT,
    parameter int                RFE_BIT   = SPI_STAT_RFE_BIT,
    parameter int                POLL_MAX  = 1023
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              start_i,
    input  logic [23:0]       flash_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i
);

    localparam int CNT_W  = LEN_W + 3;
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    rd_state_t         state;
    logic [23:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt;
    logic [POLL_W-1:0] poll_cnt;

    logic              req;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              xfer_done;
    logic [7:0]        xfer_rdata;

    logic [CNT_W-1:0]  last_idx;
    logic [CNT_W-1:0]  cnt_next;
    logic              is_hdr;
    logic              is_last;
    logic              poll_last;
    logic [7:0]        next_tx;

    apb_master_if #(.ADDR_W(ADDR_W)) u_apb (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req        (req),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .xfer_done  (xfer_done),
        .xfer_rdata (xfer_rdata),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY)
    );

    // Byte index runs over header then data; last index is len+3 so it never wraps
    assign last_idx  = CNT_W'(len_q) + CNT_W'(HDR_BYTES - 1);
    assign cnt_next  = cnt + CNT_W'(1);
    assign is_hdr    = cnt < CNT_W'(HDR_BYTES);
    assign is_last   = cnt == last_idx;
    assign poll_last = poll_cnt == POLL_W'(POLL_MAX - 1);
    assign next_tx   = (cnt_next < CNT_W'(HDR_BYTES)) ? header_byte(cnt_next[1:0], addr_q) : 8'h00;

    // Sequencer: each state owns one bus request; xfer_done advances it and queues the next one
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            poll_cnt   <= '0;
            req        <= 1'b0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q    <= flash_addr_i;
                        len_q     <= len_i;
                        cnt       <= '0;
                        poll_cnt  <= '0;
                        err_o     <= 1'b0;
                        busy_o    <= 1'b1;
                        req       <= 1'b1;
                        req_write <= 1'b1;
                        req_addr  <= REG_CTRL;
                        req_wdata <= CTRL_INIT;
                        state     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (xfer_done) begin
                        req_addr  <= REG_SS;
                        req_wdata <= 8'h01;
                        state     <= ST_CS_ON;
                    end
                end
                ST_CS_ON: begin
                    if (xfer_done) begin
                        req_addr  <= REG_DATA;
                        req_wdata <= header_byte(2'd0, addr_q);
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer_done) begin
                        req_write <= 1'b0;
                        req_addr  <= REG_STAT;
                        poll_cnt  <= '0;
                        state     <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (xfer_done) begin
                        if (!xfer_rdata[RFE_BIT]) begin
                            req_addr <= REG_DATA;
                            state    <= ST_FETCH;
                        end else if (poll_last) begin
                            // Byte never arrived: abandon the run but still release chip select
                            err_o     <= 1'b1;
                            req_write <= 1'b1;
                            req_addr  <= REG_SS;
                            req_wdata <= 8'h00;
                            state     <= ST_CS_OFF;
                        end else begin
                            poll_cnt <= poll_cnt + POLL_W'(1);
                        end
                    end
                end
                ST_FETCH: begin
                    if (xfer_done) begin
                        if (!is_hdr) begin
                            req        <= 1'b0;
                            rd_data_o  <= xfer_rdata;
                            rd_valid_o <= 1'b1;
                            state      <= ST_PUSH;
                        end else if (is_last) begin
                            req_write <= 1'b1;
                            req_addr  <= REG_SS;
                            req_wdata <= 8'h00;
                            state     <= ST_CS_OFF;
                        end else begin
                            cnt       <= cnt_next;
                            req_write <= 1'b1;
                            req_addr  <= REG_DATA;
                            req_wdata <= next_tx;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_PUSH: begin
                    if (rd_valid_o && rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        req        <= 1'b1;
                        req_write  <= 1'b1;
                        if (is_last) begin
                            req_addr  <= REG_SS;
                            req_wdata <= 8'h00;
                            state     <= ST_CS_OFF;
                        end else begin
                            cnt       <= cnt_next;
                            req_addr  <= REG_DATA;
                            req_wdata <= next_tx;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_CS_OFF: begin
                    if (xfer_done) begin
                        req    <= 1'b0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_spi_flash_reader.sv
// tb/tb_apb_spi_flash_reader.sv - randomized self-checking bench with SPI flash slave model
module tb_apb_spi_flash_reader;

    localparam int POLL_MAX = 1023;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        start_i = 1'b0;
    logic [23:0] flash_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [7:0]  PADDR;
    logic        PWRITE, PSEL, PENABLE;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA = '0;
    logic        PREADY = 1'b0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_spi_flash_reader dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start_i), .flash_addr_i(flash_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endfunction

    // configuration of the slave and stream sink for the current run
    int          cfg_max_wait = 0;
    int          cfg_rfe_polls = 0;
    int          cfg_stuck_idx = -1;
    int          cfg_stall_byte = -1;
    bit          cfg_rand_ready = 0;
    logic [23:0] run_addr = '0;

    // slave model state and logs
    logic [15:0] wr_log[$];
    logic [7:0]  stream[$];
    int          byte_idx = 0;
    logic [23:0] rx_addr = '0;
    logic [7:0]  rx_byte = '0;
    int          polls_left = 0;
    int          cur_stat_reads = 0;
    int          wait_left = 0;
    int          done_cnt = 0;
    bit          valid_seen = 0;
    bit          stalled = 0;
    int          stall_left = 0;
    logic        prev_psel = 0, prev_pen = 0, prev_rdy = 0, prev_wr = 0;
    logic [7:0]  prev_addr = '0, prev_wdata = '0;

    // SPI wrapper model: protocol monitor plus register responses with random wait states
    initial begin
        logic [31:0] rnd;
        logic        rfe;
        logic [23:0] fa;
        forever begin
            @(negedge PCLK);
            rnd = $urandom;
            if (PSEL && !PENABLE) begin
                check_eq("apb_setup_after_idle", {31'b0, prev_psel}, 0);
                wait_left = $urandom_range(cfg_max_wait, 0);
            end
            if (PENABLE) begin
                check_eq("apb_access_sequence",
                         {31'b0, PSEL && prev_psel && !(prev_pen && prev_rdy) &&
                          PADDR == prev_addr && PWRITE == prev_wr && PWDATA == prev_wdata}, 1);
            end
            PREADY = 1'b0;
            PRDATA = rnd[15:8];
            if (PSEL && PENABLE) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    PREADY = 1'b1;
                    if (PWRITE) begin
                        wr_log.push_back({PADDR, PWDATA});
                        if (PADDR == 8'h20) begin
                            byte_idx = -1;
                        end else if (PADDR == 8'h10) begin
                            byte_idx++;
                            if (byte_idx >= 1 && byte_idx <= 3) rx_addr = {rx_addr[15:0], PWDATA};
                            fa = rx_addr + 24'(byte_idx - 4);
                            rx_byte = (byte_idx < 4) ? 8'hA5 : flash_byte(fa);
                            polls_left = (byte_idx == cfg_stuck_idx) ? (1 << 30) : cfg_rfe_polls;
                            cur_stat_reads = 0;
                        end
                    end else if (PADDR == 8'h08) begin
                        cur_stat_reads++;
                        rfe = polls_left > 0;
                        if (rfe) polls_left--;
                        PRDATA = {rnd[7:1], rfe};
                    end else if (PADDR == 8'h10) begin
                        PRDATA = rx_byte;
                    end
                end
            end
            prev_psel = PSEL; prev_pen = PENABLE; prev_rdy = PREADY;
            prev_wr = PWRITE; prev_addr = PADDR; prev_wdata = PWDATA;
        end
    end

    // Stream sink: random or stalled ready, collects delivered bytes and done pulses
    initial begin
        forever begin
            @(negedge PCLK);
            if (done_o) done_cnt++;
            if (rd_valid_o) valid_seen = 1;
            if (rd_valid_o && !stalled && stream.size() == cfg_stall_byte) begin
                stalled = 1;
                stall_left = 20;
            end
            if (stall_left > 0) begin
                rd_ready_i = 1'b0;
                stall_left--;
                check_eq("stall_no_bus", {31'b0, PSEL}, 0);
                check_eq("stall_data_hold", {24'b0, rd_data_o}, {24'b0, flash_byte(run_addr + 24'd2)});
            end else begin
                rd_ready_i = cfg_rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            if (rd_valid_o && rd_ready_i) stream.push_back(rd_data_o);
        end
    end

    task automatic start_run(input logic [23:0] a, input int len);
        wr_log.delete();
        stream.delete();
        done_cnt = 0; valid_seen = 0; stalled = 0; stall_left = 0;
        run_addr = a;
        @(negedge PCLK);
        flash_addr_i = a;
        len_i = 16'(len);
        start_i = 1'b1;
        @(negedge PCLK);
        start_i = 1'b0;
        check_eq("busy_after_start", {31'b0, busy_o}, 1);
    endtask

    task automatic run(input string tag, input logic [23:0] a, input int len, output int cycles);
        int sent, ndata;
        logic [15:0] exp_wr[$];
        logic [23:0] fa;
        start_run(a, len);
        cycles = 1;
        while (!done_o && cycles < 20000) begin
            @(negedge PCLK);
            cycles++;
        end
        check_eq({tag, "_done"}, {31'b0, done_o}, 1);
        check_eq({tag, "_busy_low_at_done"}, {31'b0, busy_o}, 0);
        check_eq({tag, "_err"}, {31'b0, err_o}, {31'b0, cfg_stuck_idx >= 0});
        @(negedge PCLK);
        check_eq({tag, "_done_pulse"}, {31'b0, done_o}, 0);
        @(negedge PCLK);
        check_eq({tag, "_done_count"}, done_cnt, 1);
        sent  = (cfg_stuck_idx >= 0) ? cfg_stuck_idx + 1 : len + 4;
        ndata = (cfg_stuck_idx >= 0) ? cfg_stuck_idx - 4 : len;
        exp_wr = '{16'h0050, 16'h2001, 16'h1003, {8'h10, a[23:16]}, {8'h10, a[15:8]}, {8'h10, a[7:0]}};
        for (int i = 4; i < sent; i++) exp_wr.push_back(16'h1000);
        exp_wr.push_back(16'h2000);
        check_eq({tag, "_write_count"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < wr_log.size()) check_eq({tag, "_write"}, {16'b0, wr_log[i]}, {16'b0, exp_wr[i]});
        check_eq({tag, "_stream_len"}, stream.size(), ndata);
        for (int i = 0; i < ndata; i++) begin
            fa = a + 24'(i);
            if (i < stream.size()) check_eq({tag, "_stream_byte"}, {24'b0, stream[i]}, {24'b0, flash_byte(fa)});
        end
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge PCLK);
        check_eq("reset_outputs",
                 {15'b0, busy_o, done_o, err_o, PSEL, PENABLE, PWRITE, rd_valid_o, PADDR}, 0);
        check_eq("reset_data_outputs", {16'b0, PWDATA, rd_data_o}, 0);
        PRESETn = 1'b1;

        // directed read of 4 bytes, RFE clears after 2 polls
        cfg_rfe_polls = 2;
        run("basic", 24'h012345, 4, cyc);

        // zero-wait, immediate RFE clear: 9 cycles per header byte, 10 per data byte
        cfg_rfe_polls = 0;
        run("timing", 24'($urandom), 4, cyc);
        check_eq("timing_cycles", cyc, 46 + 10 * 4);

        // header only
        run("len0", 24'h00ABCD, 0, cyc);
        check_eq("len0_no_valid", {31'b0, valid_seen}, 0);

        // random slave wait states, RFE delays and sink backpressure
        cfg_rand_ready = 1;
        cfg_max_wait = 5;
        for (int r = 0; r < 6; r++) begin
            cfg_rfe_polls = $urandom_range(3, 0);
            run("random", 24'($urandom), $urandom_range(10, 1), cyc);
        end

        // long stall on the third data byte
        cfg_rand_ready = 0;
        cfg_max_wait = 0;
        cfg_rfe_polls = 1;
        cfg_stall_byte = 2;
        run("stall", 24'h3C0F00, 5, cyc);
        check_eq("stall_happened", {31'b0, stalled}, 1);
        cfg_stall_byte = -1;

        // RFE stuck on byte 5 (second data byte)
        cfg_stuck_idx = 5;
        run("timeout", 24'h7FFFFE, 6, cyc);
        check_eq("timeout_stat_reads", cur_stat_reads, POLL_MAX);
        cfg_stuck_idx = -1;

        // reset pulse mid-poll, then a clean run
        cfg_rfe_polls = 3;
        start_run(24'h001000, 3);
        cyc = 0;
        while (!(PSEL && PADDR == 8'h08) && cyc < 2000) begin
            @(negedge PCLK);
            cyc++;
        end
        check_eq("reached_poll", {31'b0, PSEL && PADDR == 8'h08}, 1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        check_eq("midreset_outputs",
                 {15'b0, busy_o, done_o, err_o, PSEL, PENABLE, PWRITE, rd_valid_o, PADDR}, 0);
        check_eq("midreset_data_outputs", {16'b0, PWDATA, rd_data_o}, 0);
        cfg_rfe_polls = 1;
        run("after_reset", 24'h456789, 3, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
